// File: rtl/code_defs_pkg.sv
// rtl/code_defs_pkg.sv - shared 64b/66b code definitions and TX gearbox constants
//
// Purpose : constants and types shared by the PCS encoder/decoder and the gearboxes.
// Contents: DATA_WIDTH, GB_SEQ_LEN, GB_PAUSE_START, GB_RESIDUE_W, gb_seq_t, gb_occ_t,
//           gb_take_bits() which returns how many encoder bits a given seq slot consumes.
package code_defs_pkg;

    localparam int unsigned DATA_WIDTH     = 32;
    localparam int unsigned GB_SEQ_LEN     = 66;
    localparam int unsigned GB_PAUSE_START = 64;
    // 64 residual bits plus a 34-bit even slot shifted by up to 62 still fits in 96.
    localparam int unsigned GB_RESIDUE_W   = 96;

    typedef logic [6:0] gb_seq_t;
    typedef logic [6:0] gb_occ_t;

    localparam gb_seq_t GB_SEQ_LAST   = gb_seq_t'(GB_SEQ_LEN - 1);
    localparam gb_seq_t GB_SEQ_PAUSE  = gb_seq_t'(GB_PAUSE_START);
    localparam gb_occ_t GB_OCC_MAX    = gb_occ_t'(64);

    // Even slots carry header + low half (34 bits), odd slots the high half (32 bits),
    // the two trailing slots carry nothing and only drain the residue.
    function automatic gb_occ_t gb_take_bits(input gb_seq_t seq);
        if (seq >= GB_SEQ_PAUSE) begin
            return gb_occ_t'(0);
        end else if (!seq[0]) begin
            return gb_occ_t'(34);
        end else begin
            return gb_occ_t'(32);
        end
    endfunction

endpackage

// File: rtl/tx_gearbox_if.sv
// rtl/tx_gearbox_if.sv - encoder-to-gearbox handshake interface
//
// Purpose : groups the encoder-facing data and the pause/frame-word strobes.
// Signals : txd        block half from encoder, bit [0] transmitted first
//           tx_header  2-bit sync header, meaningful only on frame_word==0 slots
//           tx_pause   1 = txd/tx_header not consumed this cycle
//           frame_word 0 = header + low half expected, 1 = high half expected
// Modports: master = encoder side, slave = gearbox side.
interface tx_gearbox_if;

    logic [code_defs_pkg::DATA_WIDTH-1:0] txd;
    logic [1:0]                           tx_header;
    logic                                 tx_pause;
    logic                                 frame_word;

    modport master (
        output txd,
        output tx_header,
        input  tx_pause,
        input  frame_word
    );

    modport slave (
        input  txd,
        input  tx_header,
        output tx_pause,
        output frame_word
    );

endinterface

// File: rtl/tx_gearbox_seq.sv
// rtl/tx_gearbox_seq.sv - 66-slot gearbox sequencer with registered strobes
//
// Purpose : seq counter 0..65 plus registered pause/frame-word decode; shared with the
//           RX block-lock sequencing.
// Ports   : i_txc        clock
//           i_reset      asynchronous active-high reset
//           o_seq        current slot number
//           o_tx_pause   1 in slots 64 and 65
//           o_frame_word seq[0] in slots 0..63, 0 in slots 64 and 65
module gearbox_seq
    import code_defs_pkg::*;
(
    input  logic    i_txc,
    input  logic    i_reset,
    output gb_seq_t o_seq,
    output logic    o_tx_pause,
    output logic    o_frame_word
);

    gb_seq_t seq_next;

    always_comb begin
        seq_next = (o_seq == GB_SEQ_LAST) ? gb_seq_t'(0) : o_seq + gb_seq_t'(1);
    end

    // Strobes are decoded from seq_next so that they are valid in the same cycle as the
    // slot they describe, without a combinational path to the encoder.
    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            o_seq        <= '0;
            o_tx_pause   <= 1'b0;
            o_frame_word <= 1'b0;
        end else begin
            o_seq        <= seq_next;
            o_tx_pause   <= (seq_next >= GB_SEQ_PAUSE);
            o_frame_word <= (seq_next < GB_SEQ_PAUSE) & seq_next[0];
        end
    end

endmodule

// File: rtl/tx_gearbox.sv
// rtl/tx_gearbox.sv - 64b/66b TX gearbox, 66-bit blocks to 32-bit transceiver words
//
// Purpose : packs header + two 32-bit halves per block into a continuous 32-bit stream;
//           32 blocks occupy 66 output cycles, two of which pause the encoder.
// Ports   : i_txc    TX clock
//           i_reset  asynchronous active-high reset
//           enc      encoder handshake (txd, tx_header in; tx_pause, frame_word out)
//           o_txd    gearboxed word, bit [0] sent first, valid every cycle after reset
module tx_gearbox
    import code_defs_pkg::*;
(
    input  logic                  i_txc,
    input  logic                  i_reset,
    tx_gearbox_if.slave           enc,
    output logic [DATA_WIDTH-1:0] o_txd
);

    gb_seq_t                   seq;
    gb_occ_t                   occ;
    gb_occ_t                   taken;
    logic [7:0]                occ_sum;
    logic [GB_RESIDUE_W-1:0]   residue;
    logic [GB_RESIDUE_W-1:0]   new_bits;
    logic [GB_RESIDUE_W-1:0]   comb_bits;

    gearbox_seq u_seq (
        .i_txc        (i_txc),
        .i_reset      (i_reset),
        .o_seq        (seq),
        .o_tx_pause   (enc.tx_pause),
        .o_frame_word (enc.frame_word)
    );

    always_comb begin
        new_bits = '0;
        taken    = gb_take_bits(seq);
        if (seq < GB_SEQ_PAUSE) begin
            if (!seq[0]) begin
                new_bits[DATA_WIDTH+1:0] = {enc.txd, enc.tx_header};
            end else begin
                new_bits[DATA_WIDTH-1:0] = enc.txd;
            end
        end
        // New bits land just above the bits still waiting to be sent.
        comb_bits = (new_bits << occ) | residue;
        occ_sum   = {1'b0, occ} + {1'b0, taken} - 8'd32;
    end

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            o_txd   <= '0;
            residue <= '0;
            occ     <= '0;
        end else begin
            o_txd   <= comb_bits[DATA_WIDTH-1:0];
            residue <= comb_bits >> DATA_WIDTH;
            occ     <= occ_sum[6:0];
        end
    end

    // An underflow wraps occ_sum above 64 as well, so one bound covers both directions.
    always_ff @(posedge i_txc) begin
        if (!i_reset) begin
            assert (occ_sum <= {1'b0, GB_OCC_MAX})
                else $error("tx_gearbox occupancy out of range: %0d", occ_sum);
        end
    end

endmodule

// File: tb/tb_tx_gearbox.sv
// tb/tb_tx_gearbox.sv - scoreboard bench for the 64b/66b TX gearbox
module tb_tx_gearbox;

    logic        clk;
    logic        rst;
    logic [31:0] o_txd;

    tx_gearbox_if gb_if ();

    tx_gearbox dut (
        .i_txc   (clk),
        .i_reset (rst),
        .enc     (gb_if.slave),
        .o_txd   (o_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          errors;
    bit          exp_q[$];
    int          tb_seq;
    bit          have_prev;
    int          mode;
    logic [1:0]  last_hdr;
    logic [31:0] last_low;
    logic [31:0] last_high;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic start_seq();
        exp_q.delete();
        have_prev = 1'b0;
        tb_seq    = 0;
    endtask

    task automatic gen_block();
        case (mode)
            0: begin
                last_hdr  = 2'b01;
                last_low  = 32'hAAAA_AAAA;
                last_high = 32'hAAAA_AAAA;
            end
            2: begin
                last_hdr  = 2'b10;
                last_low  = 32'h0000_001E;
                last_high = 32'h0000_0000;
            end
            default: begin
                last_hdr  = 2'($urandom_range(0, 3));
                last_low  = $urandom;
                last_high = $urandom;
            end
        endcase
    endtask

    // One slot: compare the word produced by the previous slot, check strobes
    // against the bench's own slot counter, then act as the encoder.
    task automatic cycle_body();
        logic [31:0] word;
        logic        exp_fw;
        logic        exp_pause;
        if (have_prev) begin
            word = '0;
            if (exp_q.size() < 32) begin
                check_val("sb_underflow", 32'(exp_q.size()), 32'd32);
            end else begin
                for (int i = 0; i < 32; i++) word[i] = exp_q.pop_front();
                check_val("txd_stream", o_txd, word);
            end
        end
        exp_pause = (tb_seq >= 64);
        exp_fw    = (tb_seq < 64) ? tb_seq[0] : 1'b0;
        check_val("frame_word", {31'b0, gb_if.frame_word}, {31'b0, exp_fw});
        check_val("tx_pause", {31'b0, gb_if.tx_pause}, {31'b0, exp_pause});

        if (gb_if.tx_pause) begin
            gb_if.txd       = $urandom;
            gb_if.tx_header = 2'($urandom_range(0, 3));
        end else if (!gb_if.frame_word) begin
            gen_block();
            gb_if.txd       = last_low;
            gb_if.tx_header = last_hdr;
            exp_q.push_back(last_hdr[0]);
            exp_q.push_back(last_hdr[1]);
            for (int i = 0; i < 32; i++) exp_q.push_back(last_low[i]);
        end else begin
            gb_if.txd       = last_high;
            gb_if.tx_header = 2'($urandom_range(0, 3));
            for (int i = 0; i < 32; i++) exp_q.push_back(last_high[i]);
        end
        have_prev = 1'b1;
        tb_seq    = (tb_seq == 65) ? 0 : tb_seq + 1;
    endtask

    task automatic run_cycle();
        @(negedge clk);
        cycle_body();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        mode            = 0;
        rst             = 1'b1;
        gb_if.txd       = '0;
        gb_if.tx_header = '0;
        start_seq();

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_txd", o_txd, 32'h0);
        check_val("reset_pause", {31'b0, gb_if.tx_pause}, 32'h0);
        check_val("reset_fw", {31'b0, gb_if.frame_word}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        start_seq();
        cycle_body();
        @(posedge clk);
        #1;
        check_val("first_word", o_txd, 32'hAAAA_AAA9);
        repeat (65) run_cycle();

        mode = 1;
        repeat (100 * 66) run_cycle();

        mode = 2;
        repeat (3 * 66) run_cycle();

        mode = 1;
        while (tb_seq != 38) run_cycle();
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_txd", o_txd, 32'h0);
        check_val("async_rst_fw", {31'b0, gb_if.frame_word}, 32'h0);
        check_val("async_rst_pause", {31'b0, gb_if.tx_pause}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start_seq();
        cycle_body();
        @(posedge clk);
        #1;
        check_val("post_reset_word", o_txd, {last_low[29:0], last_hdr});
        repeat (2 * 66 - 1) run_cycle();
        run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
